credit_pipe: RTL and testbench
==============================

// Module: credit_pipe
// PURPOSE
//  Fixed-latency delay line with valid/ready handshake on both sides. Input data
//  passes through an L-stage non-stallable valid-tagged pipe, then lands in a
//  DEPTH-entry output FIFO. Credit counting on the input side guarantees the FIFO
//  never overflows. Sits directly downstream of fixed-latency compute stages so
//  consumers can apply backpressure without stalling the datapath.
// PARAMETERS
//  DW     16  data width in bits
//  L      4   pipe latency in stages, >= 1
//  DEPTH  5   output FIFO entries = max items in flight + buffered; >= 1; L+1 gives full rate
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  in_valid   in   1   input item present
//  in_ready   out  1   block can accept an item this cycle
//  in_data    in   DW  input payload
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   consumer takes head this cycle
//  out_data   out  DW  FIFO head payload
// BEHAVIOUR
//  - Reset: all pipe valid tags 0, FIFO empty, credit count 0, pointers 0;
//    out_valid=0, out_data=0, in_ready=0 while rst is high.
//  - Accept = in_valid & in_ready; pop = out_valid & out_ready.
//  - cnt (width $clog2(DEPTH+1)) = items in pipe + items in FIFO.
//    accept only: cnt+1; pop only: cnt-1; both or neither: unchanged.
//  - in_ready = !rst & (cnt < DEPTH); combinational from cnt, never from in_valid.
//  - Pipe: stage0 <= {accept, in_data}; stage i <= stage i-1. No stall, no enable.
//    Bubbles (valid tag 0) flow through and are never written to the FIFO.
//  - FIFO write at edge when stage L-1 valid tag is 1. Accepted at edge k ->
//    written at edge k+L -> out_valid=1 in the cycle after edge k+L (latency L).
//  - No bypass: FIFO empty + write this edge -> out_valid rises next cycle only.
//  - Write and pop on the same edge are both performed; occupancy unchanged.
//  - Pointers wrap at DEPTH-1 -> 0; DEPTH need not be a power of 2.
//  - Overflow impossible by construction (cnt bounds pipe+FIFO); an assertion
//    fires if a write occurs with FIFO full or a pop with FIFO empty.
//  - out_data / out_valid stable while out_valid & !out_ready.
//  - Order preserved: output order == acceptance order.
//  - Throughput: each item holds a credit L+1 cycles minimum, so sustained
//    1 item/cycle iff DEPTH >= L+1 and out_ready held high.
//  - Reset mid-operation: all in-flight and buffered items dropped; no stale
//    item ever appears on out_* after reset deasserts.
// TESTING
//  1. Post-reset, out_ready=1: in_ready=1, out_valid=0; push 0x00A5 at edge 0 ->
//     out_valid=1 with out_data=0x00A5 in cycle after edge 4, single cycle only.
//  2. Stream 100 items (0..99) with in_valid=out_ready=1 -> in_ready never drops,
//     outputs 0..99 one per cycle after 4-cycle fill, no gaps.
//  3. out_ready=0, in_valid=1 continuously -> exactly 5 accepted, in_ready=0
//     after 5th; raise out_ready -> 5 items in order, in_ready returns next cycle
//     after first pop.
//  4. cnt=5 (full), pop and in_valid same cycle -> in_ready=0 that cycle (cnt not
//     yet decremented), next cycle in_ready=1 and accept occurs; cnt stays 5.
//  5. 3 items in flight + 2 buffered, assert rst 1 cycle -> out_valid=0 next
//     cycle, in_ready=1 after rst drops, no output for 10 cycles with no input.
//  6. Random in_valid/out_ready (50%/30%) 10k cycles, scoreboard -> order and data
//     match, cnt never > 5, overflow/underflow assertions never fire.

Source files
------------

// File: rtl/credit_pipe.sv
// Fixed-latency valid-tagged delay line feeding an output FIFO.
// Input credits bound pipe + FIFO occupancy so the FIFO cannot overflow.
module credit_pipe #(
  parameter int DW    = 16,
  parameter int L     = 4,
  parameter int DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [L-1:0]  pv_q, pv_d;
  logic [DW-1:0] pd_q [L];
  logic [DW-1:0] pd_d [L];
  logic [DW-1:0] mem_q [DEPTH];

  logic accept;
  logic pop;
  logic wr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = !rst && (cnt_q < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign out_valid = !rst && (occ_q != '0);
  assign pop       = out_valid && out_ready;
  assign wr        = pv_q[L-1];
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Non-stallable shift: bubbles travel with a 0 tag.
  always_comb begin
    pv_d    = '0;
    pv_d[0] = accept;
    pd_d[0] = in_data;
    for (int i = 1; i < L; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({wr, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pv_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pv_q     <= pv_d;
    end
  end

  // Payload storage needs no reset; validity lives in tags and occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      pd_q[i] <= pd_d[i];
    end
    if (wr) begin
      mem_q[wr_ptr_q] <= pd_q[L-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_no_ovf: assert (!wr || (occ_q < DEPTH_C));
      a_no_udf: assert (!pop || (occ_q != '0));
      a_cnt:    assert (cnt_q <= DEPTH_C);
    end
  end

endmodule

// File: tb/tb_credit_pipe.sv
// Scoreboard bench for credit_pipe: directed phases plus random traffic.
// Model: list of outstanding items, each visible L edges after acceptance.
module tb_credit_pipe;

  localparam int DW    = 16;
  localparam int L     = 4;
  localparam int DEPTH = 5;

  typedef struct {
    logic [DW-1:0] data;
    int            avail;
  } item_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  int checks   = 0;
  int failures = 0;
  int pop_cnt  = 0;
  int ecnt     = 0;

  item_t mq[$];
  logic          do_acc;
  logic          do_pop;
  logic [DW-1:0] acc_data;

  logic          s_acc;
  logic          s_ir;
  logic          s_ov;
  logic [DW-1:0] s_od;

  credit_pipe #(
    .DW(DW),
    .L(L),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs against model mid-cycle.
  always @(negedge clk) begin
    logic exp_ir;
    logic exp_ov;
    exp_ir = !rst && (mq.size() < DEPTH);
    exp_ov = !rst && (mq.size() > 0) && (mq[0].avail <= ecnt);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (out_valid && exp_ov)
      chk("out_data", {16'd0, out_data}, {16'd0, mq[0].data});
    if (rst)
      chk("out_data_rst", {16'd0, out_data}, 32'd0);
    if (out_valid && out_ready)
      pop_cnt++;
    do_acc   = in_valid && exp_ir;
    do_pop   = exp_ov && out_ready;
    acc_data = in_data;
  end

  // Model update at each edge: credit returns on the pop edge.
  always @(posedge clk) begin
    ecnt++;
    if (rst) begin
      mq.delete();
    end else begin
      if (do_pop)
        void'(mq.pop_front());
      if (do_acc)
        mq.push_back('{data: acc_data, avail: ecnt + L});
    end
  end

  task automatic step(
    input logic          v,
    input logic          r,
    input logic [DW-1:0] d
  );
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    @(negedge clk);
    s_acc = v & in_ready;
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_od  = out_data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    int sent;
    int quiet;
    int acc_cnt;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    do_acc    = 1'b0;
    do_pop    = 1'b0;
    acc_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single item latency
    step(1'b0, 1'b1, 16'h0);
    chk("t1_in_ready", {31'd0, s_ir}, 32'd1);
    chk("t1_out_valid", {31'd0, s_ov}, 32'd0);
    step(1'b1, 1'b1, 16'h00A5);
    chk("t1_accept", {31'd0, s_acc}, 32'd1);
    for (int j = 1; j <= 7; j++) begin
      step(1'b0, 1'b1, 16'h0);
      chk("t1_ov_slot", {31'd0, s_ov}, (j == 5) ? 32'd1 : 32'd0);
      if (j == 5)
        chk("t1_data", {16'd0, s_od}, 32'h00A5);
    end

    // Streaming 0..99
    base = pop_cnt;
    sent = 0;
    for (int c = 0; c < 400 && sent < 100; c++) begin
      step(1'b1, 1'b1, sent[15:0]);
      if (s_acc)
        sent++;
    end
    chk("t2_sent", sent, 100);
    repeat (10) step(1'b0, 1'b1, 16'h0);
    chk("t2_recv", pop_cnt - base, 100);

    // Fill with consumer stalled
    base = pop_cnt;
    n = 0;
    repeat (12) begin
      step(1'b1, 1'b0, 16'h0300 + n[15:0]);
      if (s_acc)
        n++;
    end
    chk("t3_accepted", n, 5);
    chk("t3_in_ready", {31'd0, s_ir}, 32'd0);

    // Pop while full: credit only returns after the edge
    step(1'b1, 1'b1, 16'h0305);
    chk("t4_ready_same", {31'd0, s_ir}, 32'd0);
    chk("t4_head_valid", {31'd0, s_ov}, 32'd1);
    chk("t4_head_data", {16'd0, s_od}, 32'h0300);
    step(1'b1, 1'b1, 16'h0305);
    chk("t4_ready_next", {31'd0, s_ir}, 32'd1);
    chk("t4_accept", {31'd0, s_acc}, 32'd1);
    repeat (12) step(1'b0, 1'b1, 16'h0);
    chk("t3_recv", pop_cnt - base, 6);

    // Reset with 2 buffered and 3 in flight
    for (int k = 0; k < 5; k++)
      step(1'b1, 1'b0, 16'h0500 + k[15:0]);
    step(1'b0, 1'b0, 16'h0);
    chk("t5_pre_valid", {31'd0, s_ov}, 32'd1);
    rst = 1'b1;
    step(1'b0, 1'b0, 16'h0);
    chk("t5_rst_ov", {31'd0, s_ov}, 32'd0);
    chk("t5_rst_ir", {31'd0, s_ir}, 32'd0);
    rst = 1'b0;
    step(1'b0, 1'b1, 16'h0);
    chk("t5_post_ov", {31'd0, s_ov}, 32'd0);
    chk("t5_post_ir", {31'd0, s_ir}, 32'd1);
    quiet = 0;
    repeat (10) begin
      step(1'b0, 1'b1, 16'h0);
      quiet += int'(s_ov);
    end
    chk("t5_quiet", quiet, 0);

    // Random traffic
    base = pop_cnt;
    acc_cnt = 0;
    repeat (10000) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) < 3),
           16'($urandom));
      acc_cnt += int'(s_acc);
    end
    repeat (30) step(1'b0, 1'b1, 16'h0);
    chk("t6_count", pop_cnt - base, acc_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
